// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed scan controller for a DIGITS-wide common-anode 7-segment
//   display. One shared external BCD->segment decoder is time-shared: the
//   current digit nibble goes out on BCD and the active-low pattern comes back
//   on SEG_IN. New values are double-buffered and only committed at a frame
//   wrap, so a frame never mixes old and new digits. Each slot begins with a
//   blank window (ghost suppression). Leading-zero blanking and decimal points
//   are supported.
// Ports
//   CLK, RST      clock (rising edge), async active-high reset
//   LOAD          capture DATA/DP into the pending buffer
//   DATA, DP      digit nibbles (digit i at DATA[4i+3:4i]) and decimal points
//   LZB           leading-zero blanking enable, sampled live
//   BCD           registered nibble to the shared decoder
//   SEG_IN        decoder output, active-low, bit7 ignored
//   SEGMENT, AN   registered segment drive / anode enables, active-low
//   ACK           1-cycle pulse when pending data is committed
//   FRAME         1-cycle pulse on every frame wrap
module seven_seg_scanner #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                LOAD,
  input  logic [4*DIGITS-1:0] DATA,
  input  logic [DIGITS-1:0]   DP,
  input  logic                LZB,
  output logic [3:0]          BCD,
  input  logic [7:0]          SEG_IN,
  output logic [7:0]          SEGMENT,
  output logic [DIGITS-1:0]   AN,
  output logic                ACK,
  output logic                FRAME
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0]            div_q, div_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [DIGITS-1:0][3:0]   disp_q, disp_d, pend_data_q, pend_data_d;
  logic [DIGITS-1:0]        dp_q, dp_d, pend_dp_q, pend_dp_d;
  logic                     pend_q, pend_d;
  logic [3:0]               bcd_q, bcd_d;
  logic [7:0]               seg_q, seg_d;
  logic [DIGITS-1:0]        an_q, an_d;
  logic                     ack_q, ack_d;
  logic                     frame_q, frame_d;
  logic                     wrap, blank, zrun;
  logic [DIGITS-1:0]        lz_mask;

  // The decoder's own DP bit is replaced by our dp register.
  logic unused_seg_dp;
  assign unused_seg_dp = SEG_IN[7];

  // lz_mask[i]: digits DIGITS-1..i are all zero. Digit 0 is never masked.
  always_comb begin
    lz_mask = '0;
    zrun    = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zrun       = zrun & (disp_q[i] == 4'h0);
      lz_mask[i] = zrun;
    end
  end

  always_comb begin
    div_d       = div_q + 1'b1;
    idx_d       = idx_q;
    wrap        = 1'b0;
    disp_d      = disp_q;
    dp_d        = dp_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;

    if (div_q == DIV_LAST) begin
      div_d = '0;
      wrap  = (idx_q == IDX_LAST);
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    if (wrap && pend_q) begin
      disp_d = pend_data_q;
      dp_d   = pend_dp_q;
      pend_d = 1'b0;
    end
    // A LOAD on the commit edge becomes the next pending frame.
    if (LOAD) begin
      pend_data_d = DATA;
      pend_dp_d   = DP;
      pend_d      = 1'b1;
    end

    // Outputs are computed from the next counter values so AN/SEGMENT line
    // up with div_cnt; SEG_IN lags idx by two cycles, hidden by the blank.
    bcd_d = disp_q[idx_q];
    blank = (div_d < BLANK_END) || (LZB && lz_mask[idx_d]);
    an_d  = '1;
    seg_d = 8'hFF;
    if (!blank) begin
      an_d[idx_d] = 1'b0;
      seg_d       = {~dp_q[idx_d], SEG_IN[6:0]};
    end
    ack_d   = wrap & pend_q;
    frame_d = wrap;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q       <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      dp_q        <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      bcd_q       <= 4'h0;
      seg_q       <= 8'hFF;
      an_q        <= '1;
      ack_q       <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      dp_q        <= dp_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      bcd_q       <= bcd_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      ack_q       <= ack_d;
      frame_q     <= frame_d;
    end
  end

  assign BCD     = bcd_q;
  assign SEGMENT = seg_q;
  assign AN      = an_q;
  assign ACK     = ack_q;
  assign FRAME   = frame_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;
  logic        CLK, RST, LOAD, LZB, ACK, FRAME;
  logic [15:0] DATA;
  logic [3:0]  DP, BCD, AN;
  logic [7:0]  SEG_IN, SEGMENT;

  int n_cmp, n_err, cyc;
  logic [13:0] sb[$];  // {FRAME, ACK, AN, SEGMENT}

  seven_seg_scanner #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .DATA(DATA), .DP(DP), .LZB(LZB),
    .BCD(BCD), .SEG_IN(SEG_IN), .SEGMENT(SEGMENT), .AN(AN), .ACK(ACK), .FRAME(FRAME)
  );

  function automatic logic [7:0] dec(input logic [3:0] b);
    case (b)
      4'h0: dec = 8'hC0; 4'h1: dec = 8'hF9; 4'h2: dec = 8'hA4; 4'h3: dec = 8'hB0;
      4'h4: dec = 8'h99; 4'h5: dec = 8'h92; 4'h6: dec = 8'h82; 4'h7: dec = 8'hF8;
      4'h8: dec = 8'h80; 4'h9: dec = 8'h90; default: dec = 8'hFF;
    endcase
  endfunction
  assign SEG_IN = dec(BCD);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bench-side slot timer: cyc % 8 = position in slot, cyc % 32 = frame position.
  always @(posedge CLK or posedge RST)
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;

  always @(negedge CLK)
    if (!RST) begin
      n_cmp++;
      if ($countones(~AN) > 1) begin
        n_err++;
        $display("FAIL an_onehot t=%0t AN=%h required at most one 0 bit", $time, AN);
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic goto(input int t);
    for (int i = 0; i < 64 && (cyc % 32) != t; i++) @(negedge CLK);
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    DATA = d; DP = p; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
  endtask

  // Expected per-cycle outputs of one frame; lit[s]=0 means slot s blanked.
  task automatic push_frame(input logic ack, input logic [3:0] lit, input logic [31:0] segs);
    logic [3:0] an;
    logic [7:0] sg;
    int s;
    for (int k = 0; k < 32; k++) begin
      s = k / 8; an = 4'hF; sg = 8'hFF;
      if ((k % 8) >= 2 && lit[s]) begin
        an = ~(4'b0001 << s);
        sg = segs[8*s +: 8];
      end
      sb.push_back({k == 0, ack && (k == 0), an, sg});
    end
  endtask

  task automatic test_reset();
    logic [13:0] e;
    RST = 1'b1; LOAD = 0; DATA = 0; DP = 0; LZB = 0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({FRAME, ACK, AN, SEGMENT, BCD} !== {1'b0, 1'b0, 4'hF, 8'hFF, 4'h0}) begin
      n_err++; $display("FAIL reset_state got %h required %h", {FRAME, ACK, AN, SEGMENT, BCD}, {1'b0, 1'b0, 4'hF, 8'hFF, 4'h0});
    end
    RST = 1'b0;
    goto(12);
    n_cmp++;
    if ({AN, SEGMENT} !== {4'hD, 8'hC0}) begin
      n_err++; $display("FAIL pre_reset_slot1 got %h required %h", {AN, SEGMENT}, {4'hD, 8'hC0});
    end
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if ({ACK, AN, SEGMENT} !== {1'b0, 4'hF, 8'hFF}) begin
      n_err++; $display("FAIL async_reset got %h required %h", {ACK, AN, SEGMENT}, {1'b0, 4'hF, 8'hFF});
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 10; k++)
      sb.push_back({2'b00, (k >= 2 && k <= 7) ? 4'hE : 4'hF, (k >= 2 && k <= 7) ? 8'hC0 : 8'hFF});
    for (int k = 0; sb.size() > 0; k++) begin
      if (k > 0) @(negedge CLK);
      e = sb.pop_front(); n_cmp++;
      if ({FRAME, ACK, AN, SEGMENT} !== e) begin
        n_err++; $display("FAIL release cyc%0d got %h required %h", k, {FRAME, ACK, AN, SEGMENT}, e);
      end
    end
  endtask

  task automatic test_commit();
    logic [13:0] e;
    goto(9);
    pulse_load(16'h1234, 4'h0);
    push_frame(1'b1, 4'hF, {8'hF9, 8'hA4, 8'hB0, 8'h99});
    goto(20); n_cmp++;
    if ({AN, SEGMENT} !== {4'hB, 8'hC0}) begin
      n_err++; $display("FAIL commit_early_slot2 got %h required %h", {AN, SEGMENT}, {4'hB, 8'hC0});
    end
    goto(28); n_cmp++;
    if ({AN, SEGMENT} !== {4'h7, 8'hC0}) begin
      n_err++; $display("FAIL commit_early_slot3 got %h required %h", {AN, SEGMENT}, {4'h7, 8'hC0});
    end
    goto(0);
    for (int k = 0; sb.size() > 0; k++) begin
      if (k > 0) @(negedge CLK);
      e = sb.pop_front(); n_cmp++;
      if ({FRAME, ACK, AN, SEGMENT} !== e) begin
        n_err++; $display("FAIL commit cyc%0d got %h required %h", k, {FRAME, ACK, AN, SEGMENT}, e);
      end
    end
  endtask

  task automatic test_lzb();
    logic [13:0] e;
    LZB = 1'b1;
    goto(9); pulse_load(16'h0045, 4'h0);
    push_frame(1'b1, 4'b0011, {8'hFF, 8'hFF, 8'h99, 8'h92});
    goto(0);
    for (int k = 0; sb.size() > 0; k++) begin
      if (k > 0) @(negedge CLK);
      e = sb.pop_front(); n_cmp++;
      if ({FRAME, ACK, AN, SEGMENT} !== e) begin
        n_err++; $display("FAIL lzb_0045 cyc%0d got %h required %h", k, {FRAME, ACK, AN, SEGMENT}, e);
      end
    end
    goto(9); pulse_load(16'h0000, 4'h0);
    push_frame(1'b1, 4'b0001, {8'hFF, 8'hFF, 8'hFF, 8'hC0});
    push_frame(1'b0, 4'b0001, {8'hFF, 8'hFF, 8'hFF, 8'hC0});
    goto(0);
    for (int k = 0; sb.size() > 0; k++) begin
      if (k > 0) @(negedge CLK);
      e = sb.pop_front(); n_cmp++;
      if ({FRAME, ACK, AN, SEGMENT} !== e) begin
        n_err++; $display("FAIL lzb_0000 cyc%0d got %h required %h", k, {FRAME, ACK, AN, SEGMENT}, e);
      end
    end
    goto(9); LZB = 1'b0;
    push_frame(1'b0, 4'hF, {4{8'hC0}});
    goto(0);
    for (int k = 0; sb.size() > 0; k++) begin
      if (k > 0) @(negedge CLK);
      e = sb.pop_front(); n_cmp++;
      if ({FRAME, ACK, AN, SEGMENT} !== e) begin
        n_err++; $display("FAIL lzb_off cyc%0d got %h required %h", k, {FRAME, ACK, AN, SEGMENT}, e);
      end
    end
  endtask

  task automatic test_dp();
    logic [13:0] e;
    goto(9); pulse_load(16'h0004, 4'b0010);
    push_frame(1'b1, 4'hF, {8'hC0, 8'hC0, 8'h40, 8'h99});
    goto(0);
    for (int k = 0; sb.size() > 0; k++) begin
      if (k > 0) @(negedge CLK);
      e = sb.pop_front(); n_cmp++;
      if ({FRAME, ACK, AN, SEGMENT} !== e) begin
        n_err++; $display("FAIL dp cyc%0d got %h required %h", k, {FRAME, ACK, AN, SEGMENT}, e);
      end
    end
    goto(9); pulse_load(16'h000A, 4'b0000);
    push_frame(1'b1, 4'hF, {8'hC0, 8'hC0, 8'hC0, 8'hFF});
    goto(0);
    for (int k = 0; sb.size() > 0; k++) begin
      if (k > 0) @(negedge CLK);
      e = sb.pop_front(); n_cmp++;
      if ({FRAME, ACK, AN, SEGMENT} !== e) begin
        n_err++; $display("FAIL hex_a cyc%0d got %h required %h", k, {FRAME, ACK, AN, SEGMENT}, e);
      end
    end
  endtask

  task automatic test_overwrite();
    logic [13:0] e;
    goto(9);  pulse_load(16'h1111, 4'h0);
    goto(17); pulse_load(16'h2222, 4'h0);
    push_frame(1'b1, 4'hF, {4{8'hA4}});
    goto(0);
    for (int k = 0; sb.size() > 0; k++) begin
      if (k > 0) @(negedge CLK);
      e = sb.pop_front(); n_cmp++;
      if ({FRAME, ACK, AN, SEGMENT} !== e) begin
        n_err++; $display("FAIL overwrite cyc%0d got %h required %h", k, {FRAME, ACK, AN, SEGMENT}, e);
      end
    end
    goto(9); pulse_load(16'h3333, 4'h0);
    push_frame(1'b1, 4'hF, {4{8'hB0}});
    push_frame(1'b1, 4'hF, {4{8'h99}});
    goto(31);
    DATA = 16'h4444; LOAD = 1'b1;  // sampled on the wrap edge
    goto(0);
    for (int k = 0; sb.size() > 0; k++) begin
      if (k > 0) @(negedge CLK);
      LOAD = 1'b0;
      e = sb.pop_front(); n_cmp++;
      if ({FRAME, ACK, AN, SEGMENT} !== e) begin
        n_err++; $display("FAIL wrap_load cyc%0d got %h required %h", k, {FRAME, ACK, AN, SEGMENT}, e);
      end
    end
  endtask

  task automatic test_reset_pending();
    logic [13:0] e;
    goto(9); pulse_load(16'h5555, 4'hF);
    goto(20);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    push_frame(1'b0, 4'hF, {4{8'hC0}});
    push_frame(1'b0, 4'hF, {4{8'hC0}});
    @(negedge CLK);
    goto(0);
    for (int k = 0; sb.size() > 0; k++) begin
      if (k > 0) @(negedge CLK);
      e = sb.pop_front(); n_cmp++;
      if ({FRAME, ACK, AN, SEGMENT} !== e) begin
        n_err++; $display("FAIL reset_pending cyc%0d got %h required %h", k, {FRAME, ACK, AN, SEGMENT}, e);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset();
    test_commit();
    test_lzb();
    test_dp();
    test_overwrite();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
